user_input_ctrl: RTL and testbench
==================================

// Module: user_input_ctrl
// PURPOSE
// Input-side counterpart to the LED output path: conditions the board's push buttons and DIP switches.
// Each input is synchronised, debounced on a shared slow tick, and edge-detected.
// Debounced changes are reported to the consuming logic through a valid/ready event port with a coalescing snapshot.
// PARAMETERS
// N_BTN     4      number of push-button inputs (active-high at this boundary)
// N_SW      8      number of DIP-switch inputs (active-high)
// TICK_DIV  12000  clk_12 cycles per debounce tick (1 ms at 12 MHz); must be >=2
// DB_TICKS  10     consecutive mismatching ticks needed to accept a new level; must be >=1
// PORTS
// clk_12       in   1            system clock, 12 MHz
// rst_n        in   1            asynchronous, active-low reset
// btn          in   N_BTN        raw button levels, asynchronous to clk_12
// dip_sw       in   N_SW         raw switch levels, asynchronous to clk_12
// btn_db       out  N_BTN        debounced button levels
// sw_db        out  N_SW         debounced switch levels
// btn_press    out  N_BTN        1-cycle pulse on debounced 0->1
// btn_release  out  N_BTN        1-cycle pulse on debounced 1->0
// evt_valid    out  1            event pending
// evt_ready    in   1            consumer accepts the event when it and evt_valid are both high
// evt_btn      out  N_BTN        debounced button snapshot for the event
// evt_sw       out  N_SW         debounced switch snapshot for the event
// evt_mask     out  N_BTN+N_SW   changed inputs: [N_BTN-1:0]=btn, [N_BTN+N_SW-1:N_BTN]=sw
// evt_merged   out  1            more than one change batch coalesced into the pending event
// BEHAVIOUR
// - Clock and reset: one clock, clk_12. rst_n is asynchronous and active-low, and clears every register.
//   All outputs read 0 in reset. Debounced state resets to 0, so any input already high at release
//   produces a normal debounce, pulse and event.
// - Synchronisation: a 2-FF synchroniser on every input bit. "sync" below means the second stage.
// - Tick prescaler: counts 0..TICK_DIV-1 and wraps. tick=1 for the single cycle where count==TICK_DIV-1.
// - Per-input debounce, with counter cnt of width clog2(DB_TICKS):
//   - If sync==db: cnt<=0 in every cycle, tick or not. A single agreeing cycle restarts qualification.
//   - If sync!=db and tick and cnt==DB_TICKS-1: db<=sync and cnt<=0. This is the update event, upd=1.
//   - If sync!=db and tick otherwise: cnt<=cnt+1.
// - Latency: from an input edge to db change is 2 sync cycles plus (DB_TICKS-1)*TICK_DIV+1 to
//   DB_TICKS*TICK_DIV cycles.
// - Pulses: btn_press/btn_release are registered and assert in the same cycle btn_db shows the new value,
//   for exactly 1 cycle. Switches have no pulses.
// - Event port: chg = per-bit upd vector for the cycle; take = evt_valid & evt_ready.
//   - !evt_valid or take, with chg!=0: load evt_btn/evt_sw with the new db values, evt_mask<=chg,
//     evt_valid<=1, evt_merged<=0. A new event replaces, not ORs.
//   - take with chg==0: evt_valid<=0 and payload holds.
//   - evt_valid & !evt_ready with chg!=0: snapshot <= new db values, evt_mask |= chg, evt_merged<=1.
//     The payload may change only in this case while valid is held; otherwise it is stable until take.
//   - No change is ever dropped. evt_mask is never 0 while evt_valid=1.
// - All bits share one tick, so simultaneous qualifications land in one chg vector and one event.
// TESTING (TICK_DIV=4, DB_TICKS=3)
// 1 Hold rst_n=0 with btn=4'hF: all outputs stay 0. Release reset: btn_db=4'hF after 11..14 cycles,
//   btn_press=4'hF for 1 cycle, evt_mask=12'h00F, evt_btn=4'hF.
// 2 With evt_ready=1, set btn[0]=1 cleanly: btn_db[0] rises 11..14 cycles later, then btn_press[0]=1
//   for 1 cycle, then evt_valid=1 for 1 cycle with evt_mask=12'h001 and evt_merged=0.
// 3 Toggle btn[1] every 5 cycles for 60 cycles, then hold 0: btn_db stays 0, no pulses, evt_valid stays 0.
// 4 With evt_ready=0, press btn[0], then 20 cycles later set dip_sw[3]=1: one event with evt_mask=12'h081,
//   evt_sw=8'h08 and evt_merged=1. Raise evt_ready: evt_valid=0 on the next cycle.
// 5 Drive evt_ready=1 in the same cycle dip_sw[0] qualifies while a btn[2] event is pending: evt_valid stays 1,
//   evt_mask=12'h010, evt_merged=0.
// 6 Pulse rst_n low for 1 cycle after 2 mismatching ticks on btn[3]: cnt is cleared, and btn_db[3] needs
//   the full 11..14 cycles after release.

Source files
------------

// File: rtl/user_input_ctrl_if.sv
// Event port between the input conditioner (master) and its consumer (slave).
// A transfer happens on a clock edge where evt_valid and evt_ready are both high.
interface user_input_ctrl_if #(
    parameter int N_BTN = 4,
    parameter int N_SW  = 8
);
    logic                   evt_valid;
    logic                   evt_ready;
    logic [N_BTN-1:0]       evt_btn;
    logic [N_SW-1:0]        evt_sw;
    logic [N_BTN+N_SW-1:0]  evt_mask;
    logic                   evt_merged;

    modport master (
        output evt_valid, evt_btn, evt_sw, evt_mask, evt_merged,
        input  evt_ready
    );

    modport slave (
        input  evt_valid, evt_btn, evt_sw, evt_mask, evt_merged,
        output evt_ready
    );
endinterface

// File: rtl/user_input_ctrl.sv
// Push-button / DIP-switch conditioner: 2-FF sync, shared-tick debounce,
// button edge pulses and a coalescing valid/ready change-event port.
module user_input_ctrl #(
    parameter int N_BTN    = 4,
    parameter int N_SW     = 8,
    parameter int TICK_DIV = 12000,
    parameter int DB_TICKS = 10
) (
    input  logic               clk_12,
    input  logic               rst_n,
    input  logic [N_BTN-1:0]   btn,
    input  logic [N_SW-1:0]    dip_sw,
    output logic [N_BTN-1:0]   btn_db,
    output logic [N_SW-1:0]    sw_db,
    output logic [N_BTN-1:0]   btn_press,
    output logic [N_BTN-1:0]   btn_release,
    user_input_ctrl_if.master  evt
);
    localparam int N  = N_BTN + N_SW;
    localparam int TW = $clog2(TICK_DIV);
    localparam int CW = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;

    logic [N-1:0]     r_sync1;
    logic [N-1:0]     r_sync2;
    logic [TW-1:0]    r_tick_cnt;
    logic             w_tick;
    logic [CW-1:0]    r_cnt [N];
    logic [N-1:0]     r_db;
    logic [N-1:0]     w_chg;
    logic [N-1:0]     w_db_nxt;
    logic [N_BTN-1:0] r_press;
    logic [N_BTN-1:0] r_release;
    logic             r_evt_valid;
    logic [N_BTN-1:0] r_evt_btn;
    logic [N_SW-1:0]  r_evt_sw;
    logic [N-1:0]     r_evt_mask;
    logic             r_evt_merged;
    logic             w_take;

    // Buttons occupy the low bits, switches the high bits, matching evt_mask.
    always_ff @(posedge clk_12 or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {dip_sw, btn};
            r_sync2 <= r_sync1;
        end
    end

    assign w_tick = (r_tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk_12 or negedge rst_n) begin
        if (!rst_n)      r_tick_cnt <= '0;
        else if (w_tick) r_tick_cnt <= '0;
        else             r_tick_cnt <= r_tick_cnt + 1'b1;
    end

    always_comb begin
        w_chg = '0;
        for (int i = 0; i < N; i++) begin
            w_chg[i] = (r_sync2[i] != r_db[i]) && w_tick && (r_cnt[i] == CW'(DB_TICKS - 1));
        end
    end

    assign w_db_nxt = r_db ^ w_chg;

    // Any agreeing cycle restarts qualification, so a bounce costs the whole window.
    always_ff @(posedge clk_12 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) r_cnt[i] <= '0;
            r_db <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (r_sync2[i] == r_db[i] || w_chg[i]) r_cnt[i] <= '0;
                else if (w_tick)                       r_cnt[i] <= r_cnt[i] + 1'b1;
            end
            r_db <= w_db_nxt;
        end
    end

    always_ff @(posedge clk_12 or negedge rst_n) begin
        if (!rst_n) begin
            r_press   <= '0;
            r_release <= '0;
        end else begin
            r_press   <= w_chg[N_BTN-1:0] &  r_sync2[N_BTN-1:0];
            r_release <= w_chg[N_BTN-1:0] & ~r_sync2[N_BTN-1:0];
        end
    end

    assign w_take = r_evt_valid & evt.evt_ready;

    // A change arriving while the event is stalled folds into it; otherwise it starts a fresh event.
    always_ff @(posedge clk_12 or negedge rst_n) begin
        if (!rst_n) begin
            r_evt_valid  <= 1'b0;
            r_evt_btn    <= '0;
            r_evt_sw     <= '0;
            r_evt_mask   <= '0;
            r_evt_merged <= 1'b0;
        end else if (w_chg != '0) begin
            r_evt_valid <= 1'b1;
            r_evt_btn   <= w_db_nxt[N_BTN-1:0];
            r_evt_sw    <= w_db_nxt[N-1:N_BTN];
            if (r_evt_valid && !w_take) begin
                r_evt_mask   <= r_evt_mask | w_chg;
                r_evt_merged <= 1'b1;
            end else begin
                r_evt_mask   <= w_chg;
                r_evt_merged <= 1'b0;
            end
        end else if (w_take) begin
            r_evt_valid <= 1'b0;
        end
    end

    assign btn_db          = r_db[N_BTN-1:0];
    assign sw_db           = r_db[N-1:N_BTN];
    assign btn_press       = r_press;
    assign btn_release     = r_release;
    assign evt.evt_valid   = r_evt_valid;
    assign evt.evt_btn     = r_evt_btn;
    assign evt.evt_sw      = r_evt_sw;
    assign evt.evt_mask    = r_evt_mask;
    assign evt.evt_merged  = r_evt_merged;
endmodule

// File: tb/tb_user_input_ctrl.sv
// Bench for user_input_ctrl: directed scenarios plus random input flipping,
// checked every cycle against a tick-counting behavioural model.
module tb_user_input_ctrl;
    localparam int N_BTN    = 4;
    localparam int N_SW     = 8;
    localparam int N        = N_BTN + N_SW;
    localparam int TICK_DIV = 4;
    localparam int DB_TICKS = 3;

    logic             clk_12;
    logic             rst_n;
    logic [N-1:0]     raw;
    logic [N_BTN-1:0] btn;
    logic [N_SW-1:0]  dip_sw;
    logic [N_BTN-1:0] btn_db;
    logic [N_SW-1:0]  sw_db;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;

    int vectors;
    int miscompares;

    user_input_ctrl_if #(.N_BTN(N_BTN), .N_SW(N_SW)) u_if ();

    assign btn    = raw[N_BTN-1:0];
    assign dip_sw = raw[N-1:N_BTN];

    user_input_ctrl #(
        .N_BTN(N_BTN), .N_SW(N_SW), .TICK_DIV(TICK_DIV), .DB_TICKS(DB_TICKS)
    ) dut (
        .clk_12      (clk_12),
        .rst_n       (rst_n),
        .btn         (btn),
        .dip_sw      (dip_sw),
        .btn_db      (btn_db),
        .sw_db       (sw_db),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .evt         (u_if.master)
    );

    // clock / reset
    initial clk_12 = 1'b0;
    always #5 clk_12 = ~clk_12;

    // behavioural model: sync delay, cycle-indexed ticks, per-input tick tally
    logic [N-1:0]     m_s1, m_s2, m_db, m_chg, m_newdb;
    int               m_ticks [N];
    int               m_cyc;
    logic             m_tick, m_take;
    logic [N_BTN-1:0] m_press, m_release, m_evt_btn;
    logic [N_SW-1:0]  m_evt_sw;
    logic [N-1:0]     m_mask;
    logic             m_valid, m_merged;

    always @(posedge clk_12 or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_db = '0; m_cyc = 0;
            for (int i = 0; i < N; i++) m_ticks[i] = 0;
            m_press = '0; m_release = '0; m_evt_btn = '0; m_evt_sw = '0;
            m_mask = '0; m_valid = 1'b0; m_merged = 1'b0;
        end else begin
            m_tick = ((m_cyc % TICK_DIV) == TICK_DIV - 1);
            m_chg  = '0;
            for (int i = 0; i < N; i++) begin
                if (m_s2[i] == m_db[i]) m_ticks[i] = 0;
                else if (m_tick) begin
                    m_ticks[i] = m_ticks[i] + 1;
                    if (m_ticks[i] == DB_TICKS) begin
                        m_chg[i]   = 1'b1;
                        m_ticks[i] = 0;
                    end
                end
            end
            m_newdb   = m_db ^ m_chg;
            m_press   = m_chg[N_BTN-1:0] & m_newdb[N_BTN-1:0];
            m_release = m_chg[N_BTN-1:0] & ~m_newdb[N_BTN-1:0];
            m_take    = m_valid && u_if.evt_ready;
            if (m_chg != '0) begin
                m_evt_btn = m_newdb[N_BTN-1:0];
                m_evt_sw  = m_newdb[N-1:N_BTN];
                if (m_valid && !m_take) begin
                    m_mask   = m_mask | m_chg;
                    m_merged = 1'b1;
                end else begin
                    m_mask   = m_chg;
                    m_merged = 1'b0;
                end
                m_valid = 1'b1;
            end else if (m_take) begin
                m_valid = 1'b0;
            end
            m_db  = m_newdb;
            m_s2  = m_s1;
            m_s1  = {dip_sw, btn};
            m_cyc = m_cyc + 1;
        end
    end

    function automatic bit will_qualify(int i);
        return (m_s2[i] != m_db[i]) && ((m_cyc % TICK_DIV) == TICK_DIV - 1)
               && (m_ticks[i] == DB_TICKS - 1);
    endfunction

    task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard: every cycle, DUT outputs versus model
    task automatic check_all();
        cmp("btn_db",      32'(btn_db),          32'(m_db[N_BTN-1:0]));
        cmp("sw_db",       32'(sw_db),           32'(m_db[N-1:N_BTN]));
        cmp("btn_press",   32'(btn_press),       32'(m_press));
        cmp("btn_release", 32'(btn_release),     32'(m_release));
        cmp("evt_valid",   32'(u_if.evt_valid),  32'(m_valid));
        cmp("evt_btn",     32'(u_if.evt_btn),    32'(m_evt_btn));
        cmp("evt_sw",      32'(u_if.evt_sw),     32'(m_evt_sw));
        cmp("evt_mask",    32'(u_if.evt_mask),   32'(m_mask));
        cmp("evt_merged",  32'(u_if.evt_merged), 32'(m_merged));
    endtask

    // driver tasks: sample at negedge, inputs change right after
    task automatic step();
        @(negedge clk_12);
        check_all();
    endtask

    task automatic steps(int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic wait_btn_db(int b, logic v, output int lat);
        lat = 99;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (btn_db[b] == v) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int  lat;
        bit  seen_db1, seen_pulse, seen_valid, found;
        vectors = 0; miscompares = 0;

        // 1: inputs high through reset
        raw = '0; raw[3:0] = 4'hF; u_if.evt_ready = 1'b0; rst_n = 1'b0;
        #1;
        steps(5);
        cmp("t1_rst_btn_db", 32'(btn_db), 32'h0);
        cmp("t1_rst_valid",  32'(u_if.evt_valid), 32'h0);
        rst_n = 1'b1;
        lat = 99;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (btn_db == 4'hF) begin lat = k; break; end
        end
        cmp("t1_latency_ok", 32'(lat >= 11 && lat <= 14), 32'h1);
        cmp("t1_press",      32'(btn_press), 32'hF);
        cmp("t1_mask",       32'(u_if.evt_mask), 32'h00F);
        cmp("t1_evt_btn",    32'(u_if.evt_btn), 32'hF);
        step();
        cmp("t1_press_gone", 32'(btn_press), 32'h0);
        u_if.evt_ready = 1'b1;
        raw[3:0] = 4'h0;
        steps(20);

        // 2: clean press with consumer ready
        raw[0] = 1'b1;
        wait_btn_db(0, 1'b1, lat);
        cmp("t2_latency_ok", 32'(lat >= 11 && lat <= 14), 32'h1);
        cmp("t2_press",      32'(btn_press), 32'h1);
        cmp("t2_valid",      32'(u_if.evt_valid), 32'h1);
        cmp("t2_mask",       32'(u_if.evt_mask), 32'h001);
        cmp("t2_merged",     32'(u_if.evt_merged), 32'h0);
        step();
        cmp("t2_valid_drop", 32'(u_if.evt_valid), 32'h0);
        cmp("t2_press_gone", 32'(btn_press), 32'h0);
        raw[0] = 1'b0;
        steps(20);

        // 3: btn[1] bouncing every 5 cycles never qualifies
        seen_db1 = 0; seen_pulse = 0; seen_valid = 0;
        for (int k = 0; k < 80; k++) begin
            if (k < 60 && (k % 5) == 0) raw[1] = ~raw[1];
            step();
            if (btn_db[1]) seen_db1 = 1;
            if (btn_press != '0 || btn_release != '0) seen_pulse = 1;
            if (u_if.evt_valid) seen_valid = 1;
        end
        cmp("t3_db_stays0", 32'(seen_db1), 32'h0);
        cmp("t3_no_pulse",  32'(seen_pulse), 32'h0);
        cmp("t3_no_event",  32'(seen_valid), 32'h0);

        // 4: stalled consumer, two changes coalesce
        u_if.evt_ready = 1'b0;
        raw[0] = 1'b1;
        steps(20);
        raw[N_BTN+3] = 1'b1;
        steps(20);
        cmp("t4_valid",   32'(u_if.evt_valid), 32'h1);
        cmp("t4_mask",    32'(u_if.evt_mask), 32'h081);
        cmp("t4_sw",      32'(u_if.evt_sw), 32'h08);
        cmp("t4_btn",     32'(u_if.evt_btn), 32'h1);
        cmp("t4_merged",  32'(u_if.evt_merged), 32'h1);
        u_if.evt_ready = 1'b1;
        step();
        cmp("t4_taken", 32'(u_if.evt_valid), 32'h0);

        // 5: take coincides with a new qualification
        u_if.evt_ready = 1'b0;
        raw[2] = 1'b1;
        found = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (u_if.evt_valid) begin found = 1; break; end
        end
        cmp("t5_btn2_event", 32'(found), 32'h1);
        raw[N_BTN+0] = 1'b1;
        found = 0;
        for (int k = 0; k < 30; k++) begin
            if (will_qualify(N_BTN)) begin found = 1; break; end
            step();
        end
        cmp("t5_sw0_predicted", 32'(found), 32'h1);
        u_if.evt_ready = 1'b1;
        step();
        cmp("t5_valid",  32'(u_if.evt_valid), 32'h1);
        cmp("t5_mask",   32'(u_if.evt_mask), 32'h010);
        cmp("t5_merged", 32'(u_if.evt_merged), 32'h0);
        cmp("t5_sw",     32'(u_if.evt_sw), 32'h09);
        step();
        cmp("t5_taken", 32'(u_if.evt_valid), 32'h0);

        // 6: reset mid-qualification restarts the full window
        raw[3] = 1'b1;
        found = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (m_ticks[3] == 2) begin found = 1; break; end
        end
        cmp("t6_two_ticks", 32'(found), 32'h1);
        rst_n = 1'b0;
        step();
        cmp("t6_rst_btn_db", 32'(btn_db), 32'h0);
        rst_n = 1'b1;
        wait_btn_db(3, 1'b1, lat);
        cmp("t6_latency_ok", 32'(lat >= 11 && lat <= 14), 32'h1);
        steps(20);

        // random phase
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 15) == 0) begin
                int idx;
                idx = $urandom_range(0, N - 1);
                raw[idx] = ~raw[idx];
            end
            u_if.evt_ready = ($urandom_range(0, 2) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
